// File: rtl/pwm_capture_if.sv
// pwm_capture_if -- signal bundle between a PWM capture block and its user.
//
// Signals
//   clockdiv    one-clock tick enable; all width/period counting uses it
//   pwm_in      asynchronous servo-style pulse input
//   endcount    maximum ticks between rising edges before timeout
//   duty        last decoded duty value (width - OFFSET, clamped)
//   duty_valid  one-clock strobe when duty/width/range_err are updated
//   width       last raw pulse width in ticks
//   range_err   last pulse was outside OFFSET..OFFSET+255
//   timeout     sticky: no rising edge within endcount+1 ticks
//   state       capture FSM state (0 SYNC, 1 ARMED, 2 HIGH), for observation
//
// Handshake: duty_valid is a pure one-cycle strobe with no ready/backpressure;
// duty, width and range_err are stable from the cycle duty_valid is high until
// the next strobe, so the consumer may sample them on the strobe or any time
// later.
//
// Modports
//   master  the user side: drives clockdiv, pwm_in, endcount
//   slave   the capture block: drives the results and the state
interface pwm_capture_if;
   logic        clockdiv;
   logic        pwm_in;
   logic [11:0] endcount;
   logic [7:0]  duty;
   logic        duty_valid;
   logic [11:0] width;
   logic        range_err;
   logic        timeout;
   logic [1:0]  state;

   modport master (
      output clockdiv, pwm_in, endcount,
      input  duty, duty_valid, width, range_err, timeout, state
   );

   modport slave (
      input  clockdiv, pwm_in, endcount,
      output duty, duty_valid, width, range_err, timeout, state
   );
endinterface

// File: rtl/pwm_capture.sv
// pwm_capture -- measures servo-style pulse width in clockdiv ticks and maps it
// to an 8-bit duty value (duty = width - OFFSET, clamped to 0..255).
//
// Ports
//   clock   system clock, all logic on its rising edge
//   reset   asynchronous, active-low reset
//   bus     pwm_capture_if.slave: clockdiv, pwm_in, endcount in;
//           duty, duty_valid, width, range_err, timeout, state out
//
// Build option
//   PWM_CAPTURE_GLITCH_FILTER_EN  when defined, the synchronized input is only
//   accepted after 3 identical consecutive clock samples (both edges delayed
//   by 2 clocks, width unchanged). When undefined the synchronized input is
//   used directly.
module pwm_capture #(
   parameter int OFFSET      = 64,
   parameter int SYNC_STAGES = 2
) (
   input logic          clock,
   input logic          reset,
   pwm_capture_if.slave bus
);

   typedef enum logic [1:0] {
      ST_SYNC  = 2'd0,
      ST_ARMED = 2'd1,
      ST_HIGH  = 2'd2
   } state_t;

   localparam logic [11:0] W_MAX = 12'hFFF;
   localparam logic [11:0] W_LO  = 12'(OFFSET);
   localparam logic [11:0] W_HI  = 12'(OFFSET + 255);

   // ---------------------------------------------------------------
   // Input synchronizer
   // ---------------------------------------------------------------
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sync_val;
   logic                   in_s;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sync_q <= '0;
      end else begin
         sync_q[0] <= bus.pwm_in;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
      end
   end

   assign sync_val = sync_q[SYNC_STAGES-1];

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
   localparam int FILT_LAT = 2;

   // Accept a new level only once the current sample and the two before it
   // agree; the combinational bypass keeps the added latency at 2 clocks.
   logic [1:0] hist_q;
   logic       filt_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         hist_q <= '0;
         filt_q <= 1'b0;
      end else begin
         hist_q <= {hist_q[0], sync_val};
         filt_q <= in_s;
      end
   end

   assign in_s = ((sync_val == hist_q[0]) && (sync_val == hist_q[1])) ? sync_val : filt_q;
`else
   localparam int FILT_LAT = 0;

   assign in_s = sync_val;
`endif

   // The synchronizer resets to 0, so right after reset it cannot yet show a
   // pulse that is already high. SYNC waits until the pipeline has been
   // refilled from the real input before trusting a low level.
   localparam logic [7:0] SETTLE = 8'(SYNC_STAGES + FILT_LAT);

   logic [7:0] settle_q;
   logic       settled;

   assign settled = (settle_q == SETTLE);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         settle_q <= '0;
      end else if (!settled) begin
         settle_q <= settle_q + 8'd1;
      end
   end

   // Edge detection runs every clock, independent of clockdiv.
   logic in_prev_q;
   logic rise;
   logic fall;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         in_prev_q <= 1'b0;
      end else begin
         in_prev_q <= in_s;
      end
   end

   assign rise = in_s & ~in_prev_q;
   assign fall = ~in_s & in_prev_q;

   // ---------------------------------------------------------------
   // Capture FSM
   // ---------------------------------------------------------------
   state_t      state_q;
   state_t      state_d;
   logic        start;
   logic        finish;
   logic        sat;
   logic [11:0] width_cnt;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= ST_SYNC;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      start   = 1'b0;
      finish  = 1'b0;
      sat     = 1'b0;
      case (state_q)
         ST_SYNC: begin
            if (settled && !in_s) state_d = ST_ARMED;
         end
         ST_ARMED: begin
            if (rise) begin
               state_d = ST_HIGH;
               start   = 1'b1;
            end
         end
         ST_HIGH: begin
            if (fall) begin
               state_d = ST_ARMED;
               finish  = 1'b1;
            end else if (bus.clockdiv && (width_cnt == W_MAX - 12'd1)) begin
               // Stuck-high: report a saturated pulse, then require a fresh
               // low level before decoding again.
               state_d = ST_SYNC;
               finish  = 1'b1;
               sat     = 1'b1;
            end
         end
         default: state_d = ST_SYNC;
      endcase
   end

   // ---------------------------------------------------------------
   // Width-to-duty mapping of the pulse being finished
   // ---------------------------------------------------------------
   logic [11:0] cap_w;
   logic [11:0] cap_diff;
   logic [7:0]  cap_duty;
   logic        cap_re;

   always_comb begin
      cap_w    = sat ? W_MAX : width_cnt;
      cap_diff = cap_w - W_LO;
      cap_duty = cap_diff[7:0];
      cap_re   = 1'b0;
      if (cap_w < W_LO) begin
         cap_duty = 8'd0;
         cap_re   = 1'b1;
      end else if (cap_w > W_HI) begin
         cap_duty = 8'd255;
         cap_re   = 1'b1;
      end
   end

   // ---------------------------------------------------------------
   // Counters and result registers
   // ---------------------------------------------------------------
   logic [11:0] period_q;
   logic [11:0] period_inc;
   logic        counting;
   logic        tick_over;
   logic [7:0]  duty_q;
   logic [11:0] width_q;
   logic        range_err_q;
   logic        duty_valid_q;
   logic        timeout_q;

   assign counting   = (state_q == ST_ARMED) || (state_q == ST_HIGH);
   assign period_inc = (period_q == W_MAX) ? W_MAX : period_q + 12'd1;
   // The rise cycle clears the period, so it never contributes to a timeout.
   assign tick_over  = bus.clockdiv && counting && !start && (period_inc > bus.endcount);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         width_cnt    <= '0;
         period_q     <= '0;
         duty_q       <= '0;
         width_q      <= '0;
         range_err_q  <= 1'b0;
         duty_valid_q <= 1'b0;
         timeout_q    <= 1'b0;
      end else begin
         // The rise-cycle strobe is the first width tick; the fall-cycle
         // strobe is not counted.
         if (start) begin
            width_cnt <= {11'd0, bus.clockdiv};
         end else if ((state_q == ST_HIGH) && (state_d == ST_HIGH) && bus.clockdiv) begin
            width_cnt <= width_cnt + 12'd1;
         end

         if (start) begin
            period_q <= '0;
         end else if (counting && bus.clockdiv) begin
            period_q <= period_inc;
         end

         duty_valid_q <= finish;
         if (finish) begin
            width_q     <= cap_w;
            duty_q      <= cap_duty;
            range_err_q <= cap_re;
         end

         // A fresh in-range pulse is newer news than a timeout tick landing
         // in the same cycle, so the clear wins.
         if (finish && !cap_re) begin
            timeout_q <= 1'b0;
         end else if (tick_over) begin
            timeout_q <= 1'b1;
         end
      end
   end

   assign bus.duty       = duty_q;
   assign bus.width      = width_q;
   assign bus.range_err  = range_err_q;
   assign bus.duty_valid = duty_valid_q;
   assign bus.timeout    = timeout_q;
   assign bus.state      = state_q;

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture -- directed, self-checking bench for pwm_capture.
// clockdiv strobes once every 4 clocks; every pulse is launched right after a
// strobe so its tick count is exact. Expected decodes are queued when a pulse
// is driven and checked when duty_valid appears.
module tb_pwm_capture;

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
   localparam int LAT    = 5;   // negedge driving fall -> posedge showing duty_valid
   localparam int TO_OFF = 4;   // shift of the tick grid relative to the rise
`else
   localparam int LAT    = 3;
   localparam int TO_OFF = 0;
`endif

   localparam logic [1:0] S_SYNC  = 2'd0;
   localparam logic [1:0] S_ARMED = 2'd1;
   localparam logic [1:0] S_HIGH  = 2'd2;

   logic clock;
   logic reset;
   logic [1:0] cd_cnt;

   pwm_capture_if bus ();

   pwm_capture dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;
   int n_pushed = 0;
   int n_dv     = 0;

   // {duty[7:0], width[11:0], range_err}
   logic [20:0] exp_q[$];

   // ---------------- clock / reset / tick enable ----------------
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      cd_cnt       = 2'd0;
      bus.clockdiv = 1'b0;
      forever begin
         @(negedge clock);
         cd_cnt       = cd_cnt + 2'd1;
         bus.clockdiv = (cd_cnt == 2'd0);
      end
   end

   // ---------------- checking helpers ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic [20:0] expect_for(input int w);
      logic [11:0] wv;
      logic [11:0] d;
      wv = 12'(w);
      if (w < 64)       return {8'd0, wv, 1'b1};
      else if (w > 319) return {8'd255, wv, 1'b1};
      d = 12'(w - 64);
      return {d[7:0], wv, 1'b0};
   endfunction

   task automatic push_exp(input int w);
      exp_q.push_back(expect_for(w));
      n_pushed++;
   endtask

   // ---------------- scoreboard monitor ----------------
   initial begin
      logic [20:0] e;
      forever begin
         @(posedge clock);
         #1;
         if (bus.duty_valid === 1'b1) begin
            n_dv++;
            n_checks++;
            assert (exp_q.size() != 0) n_pass++;
            else begin
               n_fail++;
               $error("FAIL dv_unexpected: observed duty_valid with duty %0d width %0d, expected none",
                      bus.duty, bus.width);
            end
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check("sb_duty",      {24'd0, bus.duty},      {24'd0, e[20:13]});
               check("sb_width",     {20'd0, bus.width},     {20'd0, e[12:1]});
               check("sb_range_err", {31'd0, bus.range_err}, {31'd0, e[0]});
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic wait_strobe();
      for (int i = 0; i < 8; i++) begin
         @(posedge clock);
         if (bus.clockdiv === 1'b1) break;
      end
   endtask

   task automatic idle(input int ticks);
      repeat (4 * ticks) @(negedge clock);
   endtask

   task automatic pulse(input int ticks, input bit chk_lat);
      wait_strobe();
      @(negedge clock);
      bus.pwm_in = 1'b1;
      repeat (4 * ticks) @(negedge clock);
      bus.pwm_in = 1'b0;
      if (chk_lat) begin
         repeat (LAT - 1) @(posedge clock);
         #1;
         check("dv_early", {31'd0, bus.duty_valid}, 32'd0);
         @(posedge clock);
         #1;
         check("dv_on_time", {31'd0, bus.duty_valid}, 32'd1);
      end
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      reset        = 1'b0;
      bus.pwm_in   = 1'b0;
      bus.endcount = 12'd1999;

      repeat (3) @(negedge clock);
      check("rst_duty",      {24'd0, bus.duty},       32'd0);
      check("rst_width",     {20'd0, bus.width},      32'd0);
      check("rst_dv",        {31'd0, bus.duty_valid}, 32'd0);
      check("rst_range_err", {31'd0, bus.range_err},  32'd0);
      check("rst_timeout",   {31'd0, bus.timeout},    32'd0);
      check("rst_state",     {30'd0, bus.state},      {30'd0, S_SYNC});
      reset = 1'b1;

      idle(10);
      check("armed_after_rst", {30'd0, bus.state}, {30'd0, S_ARMED});

      // Nominal pulse
      push_exp(192);
      pulse(192, 1'b1);
      check("nominal_timeout", {31'd0, bus.timeout}, 32'd0);
      idle(50);

      // Out-of-range pulses on both sides
      push_exp(40);
      pulse(40, 1'b1);
      idle(50);
      push_exp(400);
      pulse(400, 1'b1);
      idle(50);
      check("hold_duty_255", {24'd0, bus.duty},      32'd255);
      check("hold_re",       {31'd0, bus.range_err}, 32'd1);

      // Timeout: 80-tick pulse, then low; endcount=100 counted from this rise
      push_exp(80);
      wait_strobe();
      @(negedge clock);
      bus.pwm_in   = 1'b1;
      bus.endcount = 12'd100;
      repeat (320) @(negedge clock);
      bus.pwm_in = 1'b0;
      repeat (80 + TO_OFF) @(posedge clock);
      #1;
      check("to_at_tick100", {31'd0, bus.timeout}, 32'd0);
      repeat (4) @(posedge clock);
      #1;
      check("to_at_tick101", {31'd0, bus.timeout}, 32'd1);
      check("to_hold_duty",  {24'd0, bus.duty},    32'd16);
      check("to_hold_width", {20'd0, bus.width},   32'd80);
      idle(20);
      check("to_sticky", {31'd0, bus.timeout}, 32'd1);

      // A valid pulse clears the timeout
      push_exp(100);
      pulse(100, 1'b1);
      check("to_cleared", {31'd0, bus.timeout}, 32'd0);
      bus.endcount = 12'd1999;
      idle(10);
      check("to_stays_clear", {31'd0, bus.timeout}, 32'd0);

      // Stuck high beyond the width counter range
      bus.endcount = 12'd4095;
      push_exp(4095);
      wait_strobe();
      @(negedge clock);
      bus.pwm_in = 1'b1;
      repeat (4 * 4200) @(negedge clock);
      check("sat_state_sync", {30'd0, bus.state}, {30'd0, S_SYNC});
      check("sat_width",      {20'd0, bus.width}, 32'd4095);
      bus.pwm_in = 1'b0;
      idle(20);
      check("sat_rearmed", {30'd0, bus.state}, {30'd0, S_ARMED});
      push_exp(150);
      pulse(150, 1'b1);
      bus.endcount = 12'd1999;
      idle(20);

      // Reset in the middle of a 150-tick pulse
      wait_strobe();
      @(negedge clock);
      bus.pwm_in = 1'b1;
      repeat (300) @(negedge clock);
      reset = 1'b0;
      #1;
      check("midrst_duty",  {24'd0, bus.duty},       32'd0);
      check("midrst_width", {20'd0, bus.width},      32'd0);
      check("midrst_dv",    {31'd0, bus.duty_valid}, 32'd0);
      check("midrst_state", {30'd0, bus.state},      {30'd0, S_SYNC});
      repeat (4) @(negedge clock);
      reset = 1'b1;
      repeat (100) @(negedge clock);
      check("midrst_discard", {30'd0, bus.state}, {30'd0, S_SYNC});
      repeat (196) @(negedge clock);
      bus.pwm_in = 1'b0;
      idle(20);
      push_exp(150);
      pulse(150, 1'b1);
      idle(20);

      // Two-clock glitch
`ifndef PWM_CAPTURE_GLITCH_FILTER_EN
      push_exp(1);
`endif
      wait_strobe();
      @(negedge clock);
      bus.pwm_in = 1'b1;
      repeat (2) @(negedge clock);
      bus.pwm_in = 1'b0;
      repeat (3) @(negedge clock);
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
      check("glitch_no_state_change", {30'd0, bus.state}, {30'd0, S_ARMED});
`else
      check("glitch_range_err", {31'd0, bus.range_err}, 32'd1);
`endif
      idle(20);

      check("queue_drained", exp_q.size(), 32'd0);
      check("dv_count",      n_dv,         n_pushed);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/pwm_capture.md
PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 OFFSET, 64, tick count corresponding to duty 0; duty = width - OFFSET.
REQ-002 SYNC_STAGES, 2, number of flip-flops synchronizing pwm_in.
REQ-003 clock  input  1  single system clock; all logic on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 clockdiv  input  1  one-clock-wide tick enable in the clock domain; all width and period counting advances only on cycles with clockdiv=1.
REQ-006 pwm_in  input  1  asynchronous servo-style pulse input.
REQ-007 endcount  input  12  maximum ticks allowed between rising edges before timeout.
REQ-008 duty  output  8  last decoded duty value.
REQ-009 duty_valid  output  1  one-clock pulse when duty is updated.
REQ-010 width  output  12  last raw pulse width in ticks.
REQ-011 range_err  output  1  last pulse was outside OFFSET..OFFSET+255.
REQ-012 timeout  output  1  sticky; no rising edge within endcount+1 ticks.

Function
REQ-013 pwm_in SHALL pass through SYNC_STAGES flip-flops; edge detection SHALL compare the synchronized value with its previous value on every clock, independent of clockdiv.
REQ-014 FSM states SHALL be SYNC, ARMED and HIGH.
REQ-015 SYNC -> ARMED when the synchronized input is 0; no pulse is decoded in SYNC, so a pulse already in progress at reset exit is discarded.
REQ-016 ARMED -> HIGH on a rising edge; the width counter loads 0 and the period counter clears.
REQ-017 Width SHALL equal the count of clockdiv strobes on cycles where state is HIGH, including the rising-edge cycle and excluding the falling-edge cycle.
REQ-018 The width counter SHALL saturate at 4095; reaching 4095 in HIGH -> SYNC, with duty=255, range_err=1 and width=4095 written plus a duty_valid pulse.
REQ-019 HIGH -> ARMED on a falling edge; in the next cycle, width, duty and range_err update and duty_valid=1 for exactly one cycle.
REQ-020 Duty mapping: width<OFFSET -> duty=0 and range_err=1; width>OFFSET+255 -> duty=255 and range_err=1; otherwise duty=width-OFFSET (8-bit) and range_err=0.
REQ-021 The period counter (12-bit, saturating) SHALL increment on clockdiv in ARMED and HIGH; when it exceeds endcount, timeout SHALL go to 1.
REQ-022 timeout SHALL clear only on the next duty_valid with range_err=0; duty and width SHALL hold their last values during timeout.
REQ-023 A rising edge and a clockdiv strobe in the same cycle SHALL count that strobe as the first width tick and clear the period counter to 0.
REQ-024 endcount changes SHALL take effect on the next comparison; endcount=0 SHALL give timeout on the first tick after any rising edge.

Reset
REQ-025 While reset=0: state=SYNC, synchronizer and all counters 0, duty=0, width=0, duty_valid=0, range_err=0, timeout=0.
REQ-026 Reset assertion mid-pulse SHALL abort the pulse with no duty_valid.

Configuration
REQ-027 PWM_CAPTURE_GLITCH_FILTER_EN defined: the synchronized input SHALL be accepted only after 3 consecutive identical clock samples; pulses or gaps shorter than 3 clocks are ignored; both edges are delayed by 2 clocks and width is unaffected.
REQ-028 PWM_CAPTURE_GLITCH_FILTER_EN undefined: the synchronized input SHALL be used directly with no added latency.

Verification
REQ-029 clockdiv every 4 clocks, endcount=1999, pulse of 192 ticks -> duty=128, width=192, range_err=0, one duty_valid pulse 1 clock after the synchronized fall.
REQ-030 Pulses of 40 and 400 ticks -> duty=0 with range_err=1, then duty=255 with range_err=1.
REQ-031 pwm_in held low after one valid pulse, endcount=100 -> timeout=1 on the 101st tick after the rise; the next valid 100-tick pulse clears it and gives duty=36.
REQ-032 pwm_in held high for more than 4095 ticks -> duty=255, width=4095, range_err=1, then no decode until the input returns low and rises again.
REQ-033 reset asserted midway through a 150-tick pulse -> all outputs 0 immediately, no duty_valid, next full 150-tick pulse -> duty=86.
REQ-034 With the filter enabled, a 2-clock glitch high -> no state change; without the filter, the same glitch -> duty_valid with duty=0 and range_err=1.
